// File: rtl/score_keeper.sv
// score_keeper: round-tally stage for the tug-of-war game.
// Counts round wins per player, holds the playfield in reset for a settle
// interval after every round, and flags game over when a tally reaches 7.
//
// Parameters:
//   HOLD_CYCLES  minimum cycles round_reset stays high after a round (>= 1)
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   win_left     playfield level, left end light captured
//   win_right    playfield level, right end light captured
//   left_count   left player's tally (0-7), registered
//   right_count  right player's tally (0-7), registered
//   round_reset  registered, holds the playfield at its centre state
//   game_over    registered, high once a tally reaches 7
// Configuration:
//   SCORE_WRAP_EN  free-play mode: tallies wrap 7 -> 0, game_over tied low
module score_keeper #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       win_left,
  input  logic       win_right,
  output logic [2:0] left_count,
  output logic [2:0] right_count,
  output logic       round_reset,
  output logic       game_over
);

  localparam int unsigned TIMER_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    HOLD = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t             state;
  logic [TIMER_W-1:0] timer;
  logic               any_win;
  logic               max_reached;

  assign any_win     = win_left | win_right;
  assign max_reached = (left_count == 3'd7) || (right_count == 3'd7);

`ifdef SCORE_WRAP_EN
  assign game_over = 1'b0;
`endif

  // Round FSM; every output is a register updated here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= PLAY;
      timer       <= '0;
      left_count  <= 3'd0;
      right_count <= 3'd0;
      round_reset <= 1'b0;
`ifndef SCORE_WRAP_EN
      game_over   <= 1'b0;
`endif
    end else begin
      case (state)
        PLAY: begin
          if (any_win) begin
            // A simultaneous capture is a draw: settle the round, no score.
            if (win_left && !win_right) left_count <= left_count + 3'd1;
            if (win_right && !win_left) right_count <= right_count + 3'd1;
            timer       <= TIMER_LOAD;
            round_reset <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (timer != '0) begin
            timer <= timer - TIMER_W'(1);
`ifndef SCORE_WRAP_EN
          end else if (max_reached) begin
            game_over <= 1'b1;
            state     <= OVER;
`endif
          end else if (!any_win) begin
            // Stay held until the playfield releases its end light.
            round_reset <= 1'b0;
            state       <= PLAY;
          end
        end
        OVER: begin
          round_reset <= 1'b1;
`ifndef SCORE_WRAP_EN
          game_over   <= 1'b1;
`endif
        end
        default: begin
          state       <= PLAY;
          round_reset <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Testbench for score_keeper: directed scenarios plus random win traffic,
// expected outputs queued per cycle from a behavioural model and compared
// by an independent monitor.
module tb_score_keeper;

  localparam int unsigned HOLD = 4;

  logic       clk;
  logic       reset;
  logic       win_left;
  logic       win_right;
  logic [2:0] left_count;
  logic [2:0] right_count;
  logic       round_reset;
  logic       game_over;

  score_keeper #(.HOLD_CYCLES(HOLD)) dut (
    .clk         (clk),
    .reset       (reset),
    .win_left    (win_left),
    .win_right   (win_right),
    .left_count  (left_count),
    .right_count (right_count),
    .round_reset (round_reset),
    .game_over   (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Expected {left, right, round_reset, game_over} after each sampled edge.
  logic [7:0] exp_q[$];

  // Reference model: game-level view (scores, whether the playfield is held,
  // how many held cycles have elapsed, whether the game has ended).
  int m_left  = 0;
  int m_right = 0;
  bit m_held_on = 0;
  int m_held_cycles = 0;
  bit m_over = 0;

  function automatic logic [7:0] model_out();
    return {3'(m_left), 3'(m_right), 1'(m_held_on), 1'(m_over)};
  endfunction

  task automatic model_clear();
    m_left = 0; m_right = 0; m_held_on = 0; m_held_cycles = 0; m_over = 0;
  endtask

  task automatic model_step(input bit l, input bit r);
    if (m_over) begin
      // frozen
    end else if (!m_held_on) begin
      if (l || r) begin
        if (l && !r) m_left  = (m_left + 1) % 8;
        if (r && !l) m_right = (m_right + 1) % 8;
        m_held_on = 1;
        m_held_cycles = 1;
      end
    end else if (m_held_cycles < HOLD) begin
      m_held_cycles++;
`ifndef SCORE_WRAP_EN
    end else if (m_left == 7 || m_right == 7) begin
      m_over = 1;
`endif
    end else if (!l && !r) begin
      m_held_on = 0;
    end
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got L=%0d R=%0d rr=%b go=%b, expected L=%0d R=%0d rr=%b go=%b",
               name, got[7:5], got[4:2], got[1], got[0],
               want[7:5], want[4:2], want[1], want[0]);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic cyc(input bit l, input bit r);
    @(negedge clk);
    win_left  = l;
    win_right = r;
    model_step(l, r);
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0);
  endtask

  // Reset asserted between edges; outputs must clear before the next edge.
  task automatic mid_reset(input string name);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check(name, {left_count, right_count, round_reset, game_over}, 8'h00);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: compare each presented output against the queued expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        logic [7:0] want;
        want = exp_q.pop_front();
        check("cycle", {left_count, right_count, round_reset, game_over}, want);
      end
    end
  end

  initial begin
    reset = 1'b0;
    win_left = 1'b0;
    win_right = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("power_on_reset", {left_count, right_count, round_reset, game_over}, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    idle(3);

    // Single left win held for two cycles.
    cyc(1, 0); cyc(1, 0); idle(6);

    // Draw.
    cyc(1, 1); idle(6);

    // Stuck right input.
    for (int i = 0; i < 10; i++) cyc(0, 1);
    idle(3);

    // Reset in the middle of a hold interval.
    cyc(1, 0); cyc(0, 0);
    mid_reset("reset_mid_hold");
    idle(2);

    // Seven right wins, then extra wins that must be ignored (or wrap).
    for (int i = 0; i < 7; i++) begin cyc(0, 1); idle(5); end
    for (int i = 0; i < 3; i++) begin cyc(0, 1); idle(5); end
    mid_reset("reset_after_game");
    idle(2);

    // Eight left wins.
    for (int i = 0; i < 8; i++) begin cyc(1, 0); idle(5); end
    mid_reset("reset_after_left_run");

    // Random traffic with periodic resets.
    for (int blk = 0; blk < 3; blk++) begin
      for (int i = 0; i < 150; i++)
        cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      mid_reset("reset_random");
    end

    idle(2);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
